// File: rtl/im_filter_pkg.sv
// Shared definitions for the im_filter stream path: transmitter FSM states,
// data ID tags and coefficient-set sizing.
package im_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_CF  = 2'd1,
    ST_SEND_PIX = 2'd2,
    ST_DONE     = 2'd3
  } tx_state_e;

  localparam logic DATA_ID_COEF = 1'b1;
  localparam logic DATA_ID_PIX  = 1'b0;

  localparam int MASK_WIDTH_DEF = 7;
  localparam int NUM_CF         = MASK_WIDTH_DEF * MASK_WIDTH_DEF;

  function automatic int num_cf(input int mask_width);
    return mask_width * mask_width;
  endfunction

endpackage

// File: rtl/im_frame_cnt.sv
// Raster row/col position counter; last_o flags the final pixel of the frame
// so the caller can close the frame on that accept. Wraps back to origin.
module im_frame_cnt #(
  parameter int ROW_WIDTH = 640,
  parameter int COL_WIDTH = 480,
  parameter int CNT_BIT   = 10
) (
  input  logic clk,
  input  logic srst_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_BIT-1:0] row_q;
  logic [CNT_BIT-1:0] col_q;
  logic               col_wrap;

  assign col_wrap = (col_q == CNT_BIT'(ROW_WIDTH - 1));
  assign last_o   = col_wrap && (row_q == CNT_BIT'(COL_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (srst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc_i) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= last_o ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/im_stream_tx.sv
// Serialises one coefficient set and one image frame into the tagged
// data_in stream consumed by im_filter; every output is registered.
module im_stream_tx
  import im_filter_pkg::*;
#(
  parameter int DATA_BIT   = 15,
  parameter int DATA_IDBIT = 1,
  parameter int ROW_WIDTH  = 640,
  parameter int COL_WIDTH  = 480,
  parameter int MASK_WIDTH = 7,
  parameter int CNT_BIT    = 10,
  parameter int COFCNT_BIT = 15,
  parameter int PIX_BIT    = 8
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  start,
  input  logic                  skip_cf,
  input  logic                  cf_valid,
  input  logic [COFCNT_BIT-1:0] cf_data,
  output logic                  cf_ready,
  input  logic                  pix_valid,
  input  logic [PIX_BIT-1:0]    pix_data,
  output logic                  pix_ready,
  output logic                  data_in_valid,
  output logic [DATA_BIT-1:0]   data_in,
  output logic [DATA_IDBIT-1:0] data_id,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int NCF = num_cf(MASK_WIDTH);

  tx_state_e             state_q;
  logic [CNT_BIT-1:0]    cf_cnt_q;
  logic                  data_in_valid_q;
  logic [DATA_BIT-1:0]   data_in_q;
  logic [DATA_IDBIT-1:0] data_id_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  cf_acc;
  logic                  pix_acc;
  logic                  pix_last;

  // Readies decode the state alone so the sources never see a loop through us.
  assign cf_ready  = (state_q == ST_LOAD_CF);
  assign pix_ready = (state_q == ST_SEND_PIX);
  assign cf_acc    = cf_valid & cf_ready;
  assign pix_acc   = pix_valid & pix_ready;

  im_frame_cnt #(
    .ROW_WIDTH (ROW_WIDTH),
    .COL_WIDTH (COL_WIDTH),
    .CNT_BIT   (CNT_BIT)
  ) u_frame_cnt (
    .clk    (clk),
    .srst_i (reset_in),
    .inc_i  (pix_acc),
    .last_o (pix_last)
  );

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q         <= ST_IDLE;
      cf_cnt_q        <= '0;
      data_in_valid_q <= 1'b0;
      data_in_q       <= '0;
      data_id_q       <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      data_in_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= skip_cf ? ST_SEND_PIX : ST_LOAD_CF;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD_CF: begin
          if (cf_acc) begin
            data_in_valid_q <= 1'b1;
            data_in_q       <= DATA_BIT'(cf_data);
            data_id_q       <= DATA_IDBIT'(DATA_ID_COEF);
            if (cf_cnt_q == CNT_BIT'(NCF - 1)) begin
              cf_cnt_q <= '0;
              state_q  <= ST_SEND_PIX;
            end else begin
              cf_cnt_q <= cf_cnt_q + 1'b1;
            end
          end
        end
        ST_SEND_PIX: begin
          if (pix_acc) begin
            data_in_valid_q <= 1'b1;
            data_in_q       <= DATA_BIT'(pix_data);
            data_id_q       <= DATA_IDBIT'(DATA_ID_PIX);
            if (pix_last) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_in_valid = data_in_valid_q;
  assign data_in       = data_in_q;
  assign data_id       = data_id_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

endmodule
